// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg
// Shared definitions for the bit_scan_ctrl serialiser: FSM state encoding,
// default word width and the built-in word sent when no word is supplied.
package bit_scan_pkg;

  localparam int                  WIDTH_C        = 8;
  localparam logic [WIDTH_C-1:0]  DEFAULT_WORD_C = 8'hAF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bit_scan_ctrl.sv
// bit_scan_ctrl
// Serialises a WIDTH-bit config word one bit per valid/ready beat, gated by an
// enable flag latched at start. Counts transmitted ones and pulses done_o for
// one cycle at the end of each scan. All outputs come straight from flops.
//
// Optional build macro: BIT_SCAN_PARITY_EN adds one trailing even-parity beat
// after the last data bit (not counted in ones_cnt_o).
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   start_i       begin a scan (only honoured in IDLE)
//   word_valid_i  use word_i instead of DEFAULT_WORD for this scan
//   word_i        word to scan
//   enable_i      latched at start; 0 forces every transmitted bit to 0
//   bit_o         current serial bit
//   bit_valid_o   bit_o is valid
//   bit_ready_i   consumer accepts bit_o
//   index_o       bit position of bit_o within the word
//   busy_o        scan in progress
//   done_o        one-cycle pulse at scan end
//   ones_cnt_o    number of 1 data bits sent in the current/last scan
//
// state  | meaning
// IDLE   | waiting for start_i
// SEND   | presenting data bit word[idx]; advances on each transfer
// PARITY | presenting even parity of the sent bits (BIT_SCAN_PARITY_EN only)
// DONE   | done_o high for one cycle, then back to IDLE
module bit_scan_ctrl
  import bit_scan_pkg::*;
#(
  parameter int                WIDTH        = WIDTH_C,
  parameter logic [WIDTH-1:0]  DEFAULT_WORD = WIDTH'(DEFAULT_WORD_C),
  parameter bit                MSB_FIRST    = 1'b0,
  localparam int               IW           = $clog2(WIDTH),
  localparam int               CW           = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             word_valid_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             enable_i,
  output logic             bit_o,
  output logic             bit_valid_o,
  input  logic             bit_ready_i,
  output logic [IW-1:0]    index_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    ones_cnt_o
);

  localparam logic [IW-1:0] FIRST_IDX = MSB_FIRST ? IW'(WIDTH - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX  = MSB_FIRST ? '0 : IW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_word,  w_word_nxt;
  logic             r_en,    w_en_nxt;
  logic [IW-1:0]    r_idx,   w_idx_nxt;
  logic [CW-1:0]    r_ones,  w_ones_nxt;
  logic             r_bit,   w_bit_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
`ifdef BIT_SCAN_PARITY_EN
  logic             r_par,   w_par_nxt;
`endif

  logic             w_xfer;
  logic [WIDTH-1:0] w_start_word;
  logic [IW-1:0]    w_step_idx;

  assign w_xfer       = r_valid & bit_ready_i;
  assign w_start_word = word_valid_i ? word_i : DEFAULT_WORD;
  assign w_step_idx   = MSB_FIRST ? (r_idx - 1'b1) : (r_idx + 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_en    <= 1'b0;
      r_idx   <= '0;
      r_ones  <= '0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef BIT_SCAN_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_en    <= w_en_nxt;
      r_idx   <= w_idx_nxt;
      r_ones  <= w_ones_nxt;
      r_bit   <= w_bit_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef BIT_SCAN_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_en_nxt    = r_en;
    w_idx_nxt   = r_idx;
    w_ones_nxt  = r_ones;
    w_bit_nxt   = r_bit;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef BIT_SCAN_PARITY_EN
    w_par_nxt   = r_par;
`endif

    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_word_nxt  = w_start_word;
          w_en_nxt    = enable_i;
          w_idx_nxt   = FIRST_IDX;
          w_ones_nxt  = '0;
          // First bit is pre-loaded so it is valid in the cycle after start.
          w_bit_nxt   = w_start_word[FIRST_IDX] & enable_i;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SEND;
`ifdef BIT_SCAN_PARITY_EN
          w_par_nxt   = 1'b0;
`endif
        end
      end

      SEND: begin
        if (w_xfer) begin
          w_ones_nxt = r_ones + CW'(r_bit);
`ifdef BIT_SCAN_PARITY_EN
          w_par_nxt  = r_par ^ r_bit;
`endif
          if (r_idx == LAST_IDX) begin
`ifdef BIT_SCAN_PARITY_EN
            // index_o keeps the last data index during the parity beat.
            w_bit_nxt   = r_par ^ r_bit;
            w_state_nxt = PARITY;
`else
            w_bit_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
`endif
          end else begin
            w_idx_nxt = w_step_idx;
            w_bit_nxt = r_word[w_step_idx] & r_en;
          end
        end
      end

      PARITY: begin
        if (w_xfer) begin
          w_bit_nxt   = 1'b0;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end
      end

      DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bit_o       = r_bit;
  assign bit_valid_o = r_valid;
  assign index_o     = r_idx;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign ones_cnt_o  = r_ones;

endmodule

// File: doc/bit_scan_ctrl.md
Name: bit_scan_ctrl

Overview:
Sequencer that serialises an 8-bit constant/config word bit by bit through a valid/ready stream, gated by an enable flag.
- Performs the per-index bit-select and the AND-with-enable repeatedly under FSM control instead of as a single fixed index.
- Sits between a configuration source (word_i or built-in default) and a serial consumer.
- Counts the ones it transmits and reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 8, word width in bits (≥2)
DEFAULT_WORD, 8'hAF, word used when start_i arrives without word_valid_i (WIDTH bits)
MSB_FIRST, 0, 0 = scan index 0→WIDTH-1; 1 = scan WIDTH-1→0

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-low
start_i  input  1  begin a scan (sampled only in IDLE)
word_valid_i  input  1  word_i valid with start_i
word_i  input  WIDTH  word to scan
enable_i  input  1  latched at start; 0 forces all transmitted bits to 0
bit_o  output  1  current serial bit
bit_valid_o  output  1  bit_o valid
bit_ready_i  input  1  consumer accepts bit_o
index_o  output  $clog2(WIDTH)  index of bit_o within word
busy_o  output  1  scan in progress (not IDLE)
done_o  output  1  one-cycle pulse at scan end
ones_cnt_o  output  $clog2(WIDTH+1)  number of 1 data bits sent in last scan

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including ones_cnt_o and index_o. Latched word/enable cleared.
- States: IDLE, SEND, (PARITY if macro), DONE. All outputs registered.
- IDLE, start_i=1 at edge t:
  - word_q ← word_valid_i ? word_i : DEFAULT_WORD; en_q ← enable_i.
  - idx ← 0 (WIDTH-1 if MSB_FIRST); ones_cnt_o ← 0; state → SEND.
  - busy_o=1 and bit_valid_o=1 from cycle t+1.
- SEND:
  - bit_o = word_q[idx] & en_q; index_o = idx.
  - Transfer = bit_valid_o & bit_ready_i; on transfer ones_cnt_o += bit_o.
  - Last index (WIDTH-1, or 0 if MSB_FIRST): → DONE (→ PARITY with macro). Otherwise idx steps by ±1.
- Backpressure: while bit_valid_o & !bit_ready_i, bit_o, index_o and ones_cnt_o hold stable; no bit skipped or repeated.
- DONE: bit_valid_o=0, done_o=1 for exactly one cycle, busy_o stays 1, then → IDLE. ones_cnt_o holds until next start.
- start_i while busy_o=1: ignored, no effect. start_i during the DONE cycle is also ignored.
- Latency: zero backpressure, start at edge t → done_o high in cycle t+WIDTH+1 (+1 with PARITY_EN).
- No index wrap: idx never steps past the last index.
- Reset mid-scan: immediate abort to reset values; no done_o.
- Counter width: ones_cnt_o width holds WIDTH exactly, no saturation needed.

Optional Feature:
BIT_SCAN_PARITY_EN
- Defined: after the last data bit, PARITY state sends one extra beat under the same handshake.
  - bit_o = XOR of all transmitted data bits (even parity); index_o holds last data index.
  - Parity beat not counted in ones_cnt_o.
- Undefined: no PARITY state; SEND → DONE directly.

Decomposition:
- bit_scan_pkg: state_t enum (IDLE, SEND, PARITY, DONE), DEFAULT_WORD_C = 8'hAF, WIDTH_C = 8.
- Single module; the index counter and ones counter are small enough to stay inline. No sub-module.

Test Plan:
1. Default word, enable_i=1, ready=1, LSB first → bit_o 1,1,1,1,0,1,0,1; ones_cnt_o=6; done_o at t+9.
2. enable_i=0, default word → eight beats all 0; ones_cnt_o=0; done_o at t+9.
3. word_valid_i=1, word_i=8'h3C, MSB_FIRST=1 → bit_o 0,0,1,1,1,1,0,0; index_o 7..0; ones_cnt_o=4.
4. Default word, bit_ready_i low 3 cycles at index 5 → bit_o=1, index_o=5 held stable; total done at t+12; ones_cnt_o=6.
5. start_i pulsed during SEND, then rst_ni low at index 3 → second start ignored; on reset all outputs 0, state IDLE, no done_o; a new start scans from index 0.
6. BIT_SCAN_PARITY_EN defined, default word → 9th beat bit_o=0 (6 ones); word 8'h07 → parity beat 1; ones_cnt_o excludes parity.
